// File: rtl/mem_stage.sv
// MIPS memory stage: tracks the data_ok for each held load/store, buffers read
// data across writeback stalls, extracts load results and drops stale responses.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 163,
  parameter int MS_TO_WS_BUS_WD = 152
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       data_sram_dataok,
  output logic                       ms_handle_ex,
  input  logic                       ws_handle_ex,
  output logic                       ms_fwd_we,
  output logic [4:0]                 ms_fwd_dest,
  output logic [31:0]                ms_fwd_data,
  output logic                       ms_fwd_stall
);

  typedef struct packed {
    logic        store_inst;
    logic        load_inst;
    logic        ex;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0;
    logic [7:0]  cp0_addr;
    logic [31:0] rt_value;
    logic        res_from_cp0;
    logic        res_from_mem;
    logic [1:0]  addr_low;
    logic        lb, lbu, lh, lhu, lwl, lwr;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        res_from_cp0;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_bus_t;

  logic        r_ms_valid;
  es_bus_t     r_bus;
  logic        r_buf_valid;
  logic [31:0] r_buf_data;
  logic [1:0]  r_discard_cnt;

  logic        w_need_data, w_discard, w_owned, w_data_ready, w_ready_go;
  logic        w_handshake, w_discard_inc;
  logic [31:0] w_word, w_load, w_final;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  ms_bus_t     w_out;

  // Pending discards always claim a response before the current instruction does.
  assign w_need_data  = r_ms_valid && (r_bus.load_inst || r_bus.store_inst) && !r_bus.ex;
  assign w_discard    = data_sram_dataok && (r_discard_cnt != 2'd0);
  assign w_owned      = data_sram_dataok && (r_discard_cnt == 2'd0) && w_need_data && !r_buf_valid;
  assign w_data_ready = r_buf_valid || w_owned;
  assign w_ready_go   = !w_need_data || w_data_ready;

  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go && !ws_handle_ex;
  assign w_handshake    = ms_to_ws_valid && ws_allowin;
  assign w_discard_inc  = ws_handle_ex && w_need_data && !w_data_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (ws_handle_ex)    r_ms_valid <= 1'b0;
      else if (ms_allowin) r_ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin) r_bus <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (w_handshake || ws_handle_ex) begin
      r_buf_valid <= 1'b0;
    end else if (w_owned) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_discard_cnt <= 2'd0;
    else begin
      case ({w_discard_inc, w_discard})
        2'b10:   r_discard_cnt <= r_discard_cnt + 2'd1;
        2'b01:   r_discard_cnt <= r_discard_cnt - 2'd1;
        default: r_discard_cnt <= r_discard_cnt;
      endcase
    end
  end

  // Little-endian extraction; lwl/lwr merge the word with the old rt value.
  always_comb begin
    w_word = r_buf_valid ? r_buf_data : data_sram_rdata;
    w_byte = w_word[8*r_bus.addr_low +: 8];
    w_half = r_bus.addr_low[1] ? w_word[31:16] : w_word[15:0];
    w_load = w_word;
    if (r_bus.lb)       w_load = {{24{w_byte[7]}}, w_byte};
    else if (r_bus.lbu) w_load = {24'd0, w_byte};
    else if (r_bus.lh)  w_load = {{16{w_half[15]}}, w_half};
    else if (r_bus.lhu) w_load = {16'd0, w_half};
    else if (r_bus.lwl) begin
      case (r_bus.addr_low)
        2'd0:    w_load = {w_word[7:0],  r_bus.rt_value[23:0]};
        2'd1:    w_load = {w_word[15:0], r_bus.rt_value[15:0]};
        2'd2:    w_load = {w_word[23:0], r_bus.rt_value[7:0]};
        default: w_load = w_word;
      endcase
    end else if (r_bus.lwr) begin
      case (r_bus.addr_low)
        2'd0:    w_load = w_word;
        2'd1:    w_load = {r_bus.rt_value[31:24], w_word[31:8]};
        2'd2:    w_load = {r_bus.rt_value[31:16], w_word[31:16]};
        default: w_load = {r_bus.rt_value[31:8],  w_word[31:24]};
      endcase
    end
  end

  assign w_final = r_bus.res_from_mem ? w_load : r_bus.alu_result;

  always_comb begin
    w_out              = '0;
    w_out.ex           = r_bus.ex;
    w_out.exccode      = r_bus.exccode;
    w_out.bd           = r_bus.bd;
    w_out.badvaddr     = r_bus.badvaddr;
    w_out.eret         = r_bus.eret;
    w_out.mtc0         = r_bus.mtc0;
    w_out.cp0_addr     = r_bus.cp0_addr;
    w_out.cp0_wdata    = r_bus.rt_value;
    w_out.res_from_cp0 = r_bus.res_from_cp0;
    w_out.gr_we        = r_bus.gr_we && !r_bus.ex;
    w_out.dest         = r_bus.dest;
    w_out.final_result = w_final;
    w_out.pc           = r_bus.pc;
  end

  assign ms_to_ws_bus = w_out;
  assign ms_handle_ex = r_ms_valid && (r_bus.ex || r_bus.eret);
  assign ms_fwd_we    = r_ms_valid && r_bus.gr_we && !r_bus.ex;
  assign ms_fwd_dest  = r_bus.dest;
  assign ms_fwd_data  = w_final;
  assign ms_fwd_stall = r_ms_valid && (r_bus.res_from_cp0 ||
                        (r_bus.load_inst && !r_bus.ex && !w_data_ready));

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage; acts as execute stage and data SRAM,
// with load results predicted by shift/mask arithmetic.
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [162:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [151:0] ms_to_ws_bus;
  logic [31:0]  data_sram_rdata;
  logic         data_sram_dataok;
  logic         ms_handle_ex;
  logic         ws_handle_ex;
  logic         ms_fwd_we;
  logic [4:0]   ms_fwd_dest;
  logic [31:0]  ms_fwd_data;
  logic         ms_fwd_stall;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_rdata(data_sram_rdata), .data_sram_dataok(data_sram_dataok),
    .ms_handle_ex(ms_handle_ex), .ws_handle_ex(ws_handle_ex),
    .ms_fwd_we(ms_fwd_we), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data),
    .ms_fwd_stall(ms_fwd_stall)
  );

  always #5 clk = ~clk;

  localparam int K_LW = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4,
                 K_LWL = 5, K_LWR = 6, K_SW = 7, K_ALU = 8;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [162:0] mk(input int kind, input logic ex, input logic [1:0] al,
                                      input logic [31:0] rt, input logic [4:0] dest,
                                      input logic [31:0] alu, input logic [31:0] pc);
    logic st, ld, mem;
    logic [5:0] sel;
    st  = (kind == K_SW);
    ld  = (kind <= K_LWR);
    mem = ld;
    sel = 6'd0;
    if (kind >= K_LB && kind <= K_LWR) sel = 6'b100000 >> (kind - 1);
    return {st, ld, ex, (ex ? 5'd4 : 5'd0), 1'b0, alu, 1'b0, 1'b0, 8'h0, rt,
            1'b0, mem, al, sel, 1'b1, dest, alu, pc};
  endfunction

  // Reference model: byte lanes selected by shifting, lwl/lwr by masks.
  function automatic logic [31:0] ref_res(input int kind, input logic [1:0] a,
                                          input logic [31:0] w, input logic [31:0] rt,
                                          input logic [31:0] alu);
    logic [31:0] t, m;
    int sh;
    sh = 8 * int'(a);
    case (kind)
      K_LW:  return w;
      K_LB:  begin t = (w >> sh) & 32'hFF; return t[7] ? (t | 32'hFFFFFF00) : t; end
      K_LBU: return (w >> sh) & 32'hFF;
      K_LH:  begin t = (w >> (16 * int'(a[1]))) & 32'hFFFF; return t[15] ? (t | 32'hFFFF0000) : t; end
      K_LHU: return (w >> (16 * int'(a[1]))) & 32'hFFFF;
      K_LWL: begin m = (32'h1 << (24 - sh)) - 32'h1; return (w << (24 - sh)) | (rt & m); end
      K_LWR: begin m = ~(32'hFFFF_FFFF >> sh); return (w >> sh) | (rt & m); end
      default: return alu;
    endcase
  endfunction

  task automatic run_op(input string tag, input int kind, input logic [1:0] al,
                        input logic [31:0] rt, input logic [31:0] w, input int dly,
                        input int stall);
    logic [31:0] exp, pc, alu;
    logic [4:0]  dest;
    bit need, ld;
    pc   = $urandom;
    alu  = $urandom;
    dest = 5'($urandom_range(1, 31));
    need = (kind != K_ALU);
    ld   = (kind <= K_LWR);
    exp  = ref_res(kind, al, w, rt, alu);
    cyc();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(kind, 1'b0, al, rt, dest, alu, pc);
    data_sram_dataok = 1'b0; ws_allowin = 1'b1; #1;
    chk({tag, " allowin_idle"}, 32'(ms_allowin), 32'd1);
    cyc();
    es_to_ms_valid = 1'b0;
    if (need) begin
      for (int i = 0; i < dly; i++) begin
        ws_allowin = 1'($urandom_range(0, 1)); #1;
        chk({tag, " wait_valid"}, 32'(ms_to_ws_valid), 32'd0);
        chk({tag, " wait_stall"}, 32'(ms_fwd_stall), 32'(ld));
        cyc();
      end
    end
    data_sram_dataok = need; data_sram_rdata = w; ws_allowin = (stall == 0); #1;
    chk({tag, " valid"}, 32'(ms_to_ws_valid), 32'd1);
    chk({tag, " result"}, ms_to_ws_bus[63:32], exp);
    chk({tag, " pc"}, ms_to_ws_bus[31:0], pc);
    chk({tag, " fwd"}, {ms_fwd_data[26:0], ms_fwd_dest}, {exp[26:0], dest});
    chk({tag, " stall0"}, 32'(ms_fwd_stall), 32'd0);
    chk({tag, " allowin"}, 32'(ms_allowin), 32'(stall == 0));
    for (int s = 1; s < stall; s++) begin
      cyc();
      data_sram_dataok = 1'b0; data_sram_rdata = $urandom; #1;
      chk({tag, " buf_result"}, ms_fwd_data, exp);
      chk({tag, " buf_allowin"}, 32'(ms_allowin), 32'd0);
    end
    if (stall > 0) begin
      cyc();
      data_sram_dataok = 1'b0; data_sram_rdata = $urandom; ws_allowin = 1'b1; #1;
      chk({tag, " rel_valid"}, 32'(ms_to_ws_valid), 32'd1);
      chk({tag, " rel_result"}, ms_to_ws_bus[63:32], exp);
      chk({tag, " rel_allowin"}, 32'(ms_allowin), 32'd1);
    end
    cyc();
    data_sram_dataok = 1'b0; #1;
    chk({tag, " drained"}, 32'(ms_to_ws_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_rdata = '0; data_sram_dataok = 1'b0; ws_handle_ex = 1'b0;
    cyc(); cyc();
    chk("rst valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst allowin", 32'(ms_allowin), 32'd1);
    chk("rst handle_ex", 32'(ms_handle_ex), 32'd0);
    chk("rst stall", 32'(ms_fwd_stall), 32'd0);
    reset = 1'b0;

    // lw answered in its first MEM cycle
    run_op("lw100", K_LW, 2'd0, 32'h0, 32'h11223344, 0, 0);
    // lb from byte 3 held in the read buffer for three stalled cycles
    run_op("lb3", K_LB, 2'd3, 32'h0, 32'h80FFFFFF, 0, 3);
    run_op("lwr2", K_LWR, 2'd2, 32'hAABBCCDD, 32'h11223344, 1, 0);
    run_op("lwl1", K_LWL, 2'd1, 32'hAABBCCDD, 32'h11223344, 0, 1);
    chk("lwr2_model", ref_res(K_LWR, 2'd2, 32'h11223344, 32'hAABBCCDD, 0), 32'hAABB1122);
    chk("lwl1_model", ref_res(K_LWL, 2'd1, 32'h11223344, 32'hAABBCCDD, 0), 32'h3344CCDD);
    // sw with data_ok two cycles late
    run_op("sw", K_SW, 2'd0, 32'h5, 32'h0, 2, 0);

    // Flush while a load waits: the next response belongs to nobody
    cyc();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 1'b0, 2'd0, 0, 5'd3, 32'h200, 32'h400);
    cyc();
    es_to_ms_valid = 1'b0; ws_handle_ex = 1'b1; #1;
    chk("flush valid", 32'(ms_to_ws_valid), 32'd0);
    cyc();
    ws_handle_ex = 1'b0; #1;
    chk("flush cleared", 32'(ms_allowin), 32'd1);
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 1'b0, 2'd0, 0, 5'd4, 32'h300, 32'h404);
    cyc();
    es_to_ms_valid = 1'b0; data_sram_dataok = 1'b1; data_sram_rdata = 32'hDEAD; #1;
    chk("stale valid", 32'(ms_to_ws_valid), 32'd0);
    chk("stale stall", 32'(ms_fwd_stall), 32'd1);
    cyc();
    data_sram_rdata = 32'h1234; #1;
    chk("fresh valid", 32'(ms_to_ws_valid), 32'd1);
    chk("fresh result", ms_to_ws_bus[63:32], 32'h1234);
    cyc();
    data_sram_dataok = 1'b0; #1;
    chk("fresh drained", 32'(ms_to_ws_valid), 32'd0);

    // Load with address exception never waits for data
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 1'b1, 2'd1, 0, 5'd7, 32'h101, 32'h500);
    cyc();
    es_to_ms_valid = 1'b0; #1;
    chk("adel valid", 32'(ms_to_ws_valid), 32'd1);
    chk("adel handle_ex", 32'(ms_handle_ex), 32'd1);
    chk("adel gr_we", 32'(ms_to_ws_bus[69]), 32'd0);
    chk("adel fwd_we", 32'(ms_fwd_we), 32'd0);
    chk("adel stall", 32'(ms_fwd_stall), 32'd0);
    run_op("after_adel", K_LW, 2'd0, 0, 32'hCAFEF00D, 0, 0);

    // Reset while a load is outstanding
    cyc();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LH, 1'b0, 2'd2, 0, 5'd9, 32'h8, 32'h600);
    cyc();
    es_to_ms_valid = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0; #1;
    chk("midrst valid", 32'(ms_to_ws_valid), 32'd0);
    chk("midrst allowin", 32'(ms_allowin), 32'd1);
    chk("midrst stall", 32'(ms_fwd_stall), 32'd0);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 8);
      run_op($sformatf("rnd%0d_k%0d", n, k), k, 2'($urandom_range(0, 3)), $urandom,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the five-stage MIPS pipeline, between the execute stage and writeback.
- Accepts the execute-stage bus and waits for the SRAM-like data_ok response of each load or store it holds.
- Buffers read data when writeback stalls, performs load byte/half/unaligned extraction and merge, and forwards the result to writeback and to decode bypass.
- Discards stale data responses after an exception flush.

Parameters:
ES_TO_MS_BUS_WD, 163, width of incoming execute bus
MS_TO_WS_BUS_WD, 152, width of outgoing writeback bus

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
ws_allowin  in  1  writeback can accept
ms_allowin  out  1  this stage can accept
es_to_ms_valid  in  1  execute bus valid
es_to_ms_bus  in  163  {store_inst[162], load_inst[161], ex[160], exccode[159:155], bd[154], badvaddr[153:122], eret[121], mtc0[120], cp0_addr[119:112], rt_value[111:80], res_from_cp0[79], res_from_mem[78], addr_low[77:76], lb,lbu,lh,lhu,lwl,lwr[75:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
ms_to_ws_valid  out  1  writeback bus valid
ms_to_ws_bus  out  152  {ex, exccode[5], bd, badvaddr[32], eret, mtc0, cp0_addr[8], cp0_wdata[32], res_from_cp0, gr_we, dest[5], final_result[32], pc[32]}, MSB first
data_sram_rdata  in  32  read data
data_sram_dataok  in  1  response strobe, at most one per cycle
ms_handle_ex  out  1  ms_valid && (ex || eret)
ws_handle_ex  in  1  flush from writeback
ms_fwd_we  out  1  ms_valid && gr_we && !ex
ms_fwd_dest  out  5  destination register
ms_fwd_data  out  32  final_result
ms_fwd_stall  out  1  ms_valid && (res_from_cp0 || (load_inst && !ex && !data_ready)); decode must not bypass

Behaviour:
- Stage control:
  - ms_valid: reset 0; ws_handle_ex -> 0; else if ms_allowin -> es_to_ms_valid.
  - Bus register loads on es_to_ms_valid && ms_allowin.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go && !ws_handle_ex.
- Response expectation:
  - mem_inst = load_inst || store_inst.
  - An instruction with ex=1 never issued a request and expects no response.
  - need_data = ms_valid && mem_inst && !ex.
- data_ok ownership:
  - Any data_ok is first charged to discard_cnt (2-bit, reset 0): if discard_cnt != 0, the response is dropped and the counter decrements.
  - Otherwise, if need_data && !buf_valid, it belongs to the current instruction.
- Read buffer:
  - buf_valid/buf_data reset 0.
  - Set (capture rdata) on an owned data_ok when !(ms_to_ws_valid && ws_allowin).
  - Clear on ms_to_ws handshake or ws_handle_ex.
- Ready logic:
  - data_ready = buf_valid || owned data_ok this cycle.
  - ms_ready_go = !need_data || data_ready.
  - The load word used is buf_valid ? buf_data : data_sram_rdata.
- Flush with pending response: if ws_handle_ex && need_data && !data_ready, discard_cnt increments. Same-cycle decrement and increment leave it unchanged. Saturation is never reached; at most 2 responses are outstanding.
- A new instruction may enter while discard_cnt != 0; its own response is the one after the discards.
- Load extraction (little-endian, w = word, b0..b3 its bytes, rt = rt_value), by addr_low:
  - lb/lbu: sign/zero-extended byte b[addr_low].
  - lh/lhu: half at addr_low[1] (0 -> w[15:0], 1 -> w[31:16]), extended.
  - lw: w.
  - lwl: 0 -> {b0, rt[23:0]}; 1 -> {w[15:0], rt[15:0]}; 2 -> {w[23:0], rt[7:0]}; 3 -> w.
  - lwr: 0 -> w; 1 -> {rt[31:24], w[31:8]}; 2 -> {rt[31:16], w[31:16]}; 3 -> {rt[31:8], w[31:24]}.
- Result and output bus:
  - final_result = res_from_mem ? load_data : alu_result.
  - cp0_wdata = rt_value.
  - Outgoing gr_we is forced 0 when ex=1.
- Reset mid-operation: all state clears; outstanding responses after reset are not expected.

Test Plan:
- lw at 0x100; data_ok with 0x11223344 in first MEM cycle, ws_allowin=1 -> ms_to_ws_valid same cycle, final_result=0x11223344, buf_valid stays 0.
- lb addr_low=3, rdata 0x80FFFFFF, ws_allowin=0 for 3 cycles -> buf holds data, final_result=0xFFFFFF80 constant, ms_allowin=0 until ws_allowin=1.
- lwr addr_low=2, rt=0xAABBCCDD, word 0x11223344 -> 0xAABB1122; lwl addr_low=1 same inputs -> 0x3344CCDD.
- Load waiting, ws_handle_ex pulse -> ms_valid=0, discard_cnt=1. New lw enters; first data_ok (0xDEAD) dropped, second (0x1234) -> final_result=0x1234.
- Load with ex=1 (ADEL) -> ms_ready_go=1 immediately, no data_ok consumed, ms_handle_ex=1, outgoing gr_we=0.
- Store sw: data_ok delayed 2 cycles -> ms_fwd_stall=0, ms_to_ws_valid asserted only in the data_ok cycle.
